// File: rtl/ei_axi4_rd_arb_pkg.sv
// Shared types and helpers for the AXI4 read-path arbiter and its round-robin picker.
package ei_axi4_rd_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    localparam int unsigned OUTS_W = 4;

    // Width of a master index; a lone master still needs one bit of prefix.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ei_axi4_rr_arbiter.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module ei_axi4_rr_arbiter
    import ei_axi4_rd_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int unsigned     cand;
    logic [IW-1:0]   cidx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last) + i) % N;
            cidx = IW'(cand);
            if (!any && req[cidx]) begin
                any          = 1'b1;
                gnt_oh[cidx] = 1'b1;
                gnt_idx      = cidx;
            end
        end
    end

endmodule

// File: rtl/ei_axi4_rd_arbiter.sv
// Shares one AXI4 slave read port among NUM_MST masters: round-robin AR grant with
// index-prefixed IDs, prefix-routed R beats, and a per-master outstanding-burst cap.
module ei_axi4_rd_arbiter
    import ei_axi4_rd_arb_pkg::*;
#(
    parameter  int unsigned NUM_MST  = 2,
    parameter  int unsigned ID_W     = 4,
    parameter  int unsigned ADDR_W   = 32,
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned MAX_OUTS = 4,
    localparam int unsigned IDX_W    = idx_width(NUM_MST),
    localparam int unsigned SID_W    = ID_W + IDX_W
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_MST-1:0]        s_arvalid,
    output logic [NUM_MST-1:0]        s_arready,
    input  logic [NUM_MST*ADDR_W-1:0] s_araddr,
    input  logic [NUM_MST*ID_W-1:0]   s_arid,
    input  logic [NUM_MST*8-1:0]      s_arlen,
    input  logic [NUM_MST*3-1:0]      s_arsize,
    input  logic [NUM_MST*2-1:0]      s_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic [SID_W-1:0]          m_arid,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [SID_W-1:0]          m_rid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    output logic [NUM_MST-1:0]        s_rvalid,
    input  logic [NUM_MST-1:0]        s_rready,
    output logic [ID_W-1:0]           s_rid,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      err_unrouted
);

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    g, last_g, pick_idx, r;
    logic [NUM_MST-1:0]  g_oh, pick_oh, eligible, outs_inc, outs_dec;
    logic                pick_any, ar_hs, r_unrouted, r_sel_ready;
    logic [OUTS_W-1:0]   outs [NUM_MST];

    always_comb begin
        for (int unsigned k = 0; k < NUM_MST; k++) begin
            eligible[k] = s_arvalid[k] && (outs[k] < OUTS_W'(MAX_OUTS));
        end
    end

    ei_axi4_rr_arbiter #(
        .N  (NUM_MST),
        .IW (IDX_W)
    ) u_rr (
        .req     (eligible),
        .last    (last_g),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_nxt = state;
        m_arvalid = 1'b0;
        s_arready = '0;
        case (state)
            IDLE: if (pick_any) state_nxt = GRANT;
            GRANT: begin
                m_arvalid = 1'b1;
                s_arready = g_oh & {NUM_MST{m_arready}};
                if (m_arready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ar_hs = m_arvalid && m_arready;

    always_comb begin
        m_araddr  = s_araddr[32'(g)*ADDR_W +: ADDR_W];
        m_arlen   = s_arlen[32'(g)*8 +: 8];
        m_arsize  = s_arsize[32'(g)*3 +: 3];
        m_arburst = s_arburst[32'(g)*2 +: 2];
        m_arid    = {g, s_arid[32'(g)*ID_W +: ID_W]};
    end

    // Out-of-range prefixes are swallowed so a bad ID cannot stall the slave.
    assign r          = m_rid[SID_W-1:ID_W];
    assign r_unrouted = 32'(r) >= NUM_MST;

    always_comb begin
        s_rvalid    = '0;
        r_sel_ready = 1'b0;
        for (int unsigned k = 0; k < NUM_MST; k++) begin
            if (r == IDX_W'(k)) begin
                s_rvalid[k] = m_rvalid;
                r_sel_ready = s_rready[k];
            end
        end
    end

    assign m_rready = r_unrouted ? 1'b1 : r_sel_ready;
    assign s_rid    = m_rid[ID_W-1:0];
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

    assign outs_inc = g_oh & {NUM_MST{ar_hs}};
    assign outs_dec = s_rvalid & s_rready & {NUM_MST{m_rlast}};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= IDLE;
            g            <= '0;
            g_oh         <= '0;
            last_g       <= IDX_W'(NUM_MST - 1);
            err_unrouted <= 1'b0;
            for (int unsigned k = 0; k < NUM_MST; k++) outs[k] <= '0;
        end else begin
            state        <= state_nxt;
            err_unrouted <= m_rvalid && r_unrouted;
            if (state == IDLE && pick_any) begin
                g    <= pick_idx;
                g_oh <= pick_oh;
            end
            if (ar_hs) last_g <= g;
            // A same-cycle grant and burst completion cancel out.
            for (int unsigned k = 0; k < NUM_MST; k++) begin
                if (outs_inc[k] && !outs_dec[k])
                    outs[k] <= outs[k] + OUTS_W'(1);
                else if (outs_dec[k] && !outs_inc[k] && outs[k] != '0)
                    outs[k] <= outs[k] - OUTS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ei_axi4_rd_arbiter.sv
// Randomized bench for ei_axi4_rd_arbiter with a transaction-level reference model
// (pending-burst queue for outstanding counts, arithmetic round-robin pick).
module tb_ei_axi4_rd_arbiter;

    localparam int unsigned N        = 3;
    localparam int unsigned ID_W     = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_OUTS = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned SID_W    = ID_W + IDX_W;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [N-1:0]          s_arvalid, s_arready;
    logic [N*ADDR_W-1:0]   s_araddr;
    logic [N*ID_W-1:0]     s_arid;
    logic [N*8-1:0]        s_arlen;
    logic [N*3-1:0]        s_arsize;
    logic [N*2-1:0]        s_arburst;
    logic                  m_arvalid, m_arready;
    logic [ADDR_W-1:0]     m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic [SID_W-1:0]      m_arid;
    logic                  m_rvalid, m_rready;
    logic [SID_W-1:0]      m_rid;
    logic [DATA_W-1:0]     m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;
    logic [N-1:0]          s_rvalid, s_rready;
    logic [ID_W-1:0]       s_rid;
    logic [DATA_W-1:0]     s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rlast;
    logic                  err_unrouted;

    ei_axi4_rd_arbiter #(
        .NUM_MST  (N),
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_OUTS (MAX_OUTS)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_araddr     (s_araddr),
        .s_arid       (s_arid),
        .s_arlen      (s_arlen),
        .s_arsize     (s_arsize),
        .s_arburst    (s_arburst),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_araddr     (m_araddr),
        .m_arlen      (m_arlen),
        .m_arsize     (m_arsize),
        .m_arburst    (m_arburst),
        .m_arid       (m_arid),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready),
        .m_rid        (m_rid),
        .m_rdata      (m_rdata),
        .m_rresp      (m_rresp),
        .m_rlast      (m_rlast),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .s_rid        (s_rid),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rlast      (s_rlast),
        .err_unrouted (err_unrouted)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int unsigned     idx;
        logic [ID_W-1:0] id;
        int unsigned     len;
        int unsigned     beat;
    } burst_t;

    burst_t              pend_q[$];
    logic                req_v    [N];
    logic [ADDR_W-1:0]   req_addr [N];
    logic [ID_W-1:0]     req_id   [N];
    logic [7:0]          req_len  [N];
    logic [2:0]          req_size [N];
    logic [1:0]          req_bst  [N];

    bit          exp_busy;
    int unsigned exp_g, exp_last;
    bit          exp_err;
    int unsigned n_tests, n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned outs_of(input int unsigned k);
        int unsigned c = 0;
        foreach (pend_q[i]) if (pend_q[i].idx == k) c++;
        return c;
    endfunction

    task automatic drive_masters();
        for (int unsigned k = 0; k < N; k++) begin
            s_arvalid[k]                  = req_v[k];
            s_araddr[k*ADDR_W +: ADDR_W]  = req_addr[k];
            s_arid[k*ID_W +: ID_W]        = req_id[k];
            s_arlen[k*8 +: 8]             = req_len[k];
            s_arsize[k*3 +: 3]            = req_size[k];
            s_arburst[k*2 +: 2]           = req_bst[k];
        end
    endtask

    task automatic new_req(input int unsigned k);
        req_v[k]    = 1'b1;
        req_addr[k] = $urandom;
        req_id[k]   = ID_W'($urandom);
        req_len[k]  = 8'($urandom_range(3));
        req_size[k] = 3'($urandom);
        req_bst[k]  = 2'($urandom_range(2));
    endtask

    // One clock cycle: drive at negedge, check, then advance the model to the next edge.
    task automatic step(input bit rst, input int unsigned ar_pct,
                        input int unsigned rdy_pct, input int unsigned r_pct);
        bit              unr, found, r_hs;
        int unsigned     rr, c;
        logic [N-1:0]    exp_rdy, exp_rv;
        burst_t          b;
        @(negedge aclk);
        areset = rst;
        for (int unsigned k = 0; k < N; k++)
            if (!req_v[k] && $urandom_range(99) < ar_pct) new_req(k);
        drive_masters();
        m_arready = !rst && ($urandom_range(99) < rdy_pct);
        m_rvalid  = 1'b0;
        m_rid     = '0;
        m_rlast   = 1'b0;
        m_rdata   = $urandom;
        m_rresp   = 2'($urandom);
        s_rready  = N'($urandom_range(7) | $urandom_range(7));
        unr = 1'b0;
        rr  = 0;
        if (!rst && $urandom_range(99) < r_pct) begin
            if ($urandom_range(19) == 0) begin
                m_rvalid = 1'b1;
                unr      = 1'b1;
                m_rid    = {2'd3, ID_W'($urandom)};
                m_rlast  = 1'($urandom);
            end else if (pend_q.size() > 0) begin
                m_rvalid = 1'b1;
                rr       = pend_q[0].idx;
                m_rid    = {IDX_W'(pend_q[0].idx), pend_q[0].id};
                m_rlast  = (pend_q[0].beat == pend_q[0].len);
            end
        end
        #1;
        check_eq("m_arvalid", m_arvalid, exp_busy);
        exp_rdy = '0;
        if (exp_busy) exp_rdy[exp_g] = m_arready;
        check_eq("s_arready", s_arready, exp_rdy);
        if (exp_busy) begin
            check_eq("m_arid",    m_arid,    {IDX_W'(exp_g), req_id[exp_g]});
            check_eq("m_araddr",  m_araddr,  req_addr[exp_g]);
            check_eq("m_arlen",   m_arlen,   req_len[exp_g]);
            check_eq("m_arsize",  m_arsize,  req_size[exp_g]);
            check_eq("m_arburst", m_arburst, req_bst[exp_g]);
        end
        exp_rv = '0;
        if (m_rvalid && !unr) exp_rv[rr] = 1'b1;
        check_eq("s_rvalid", s_rvalid, exp_rv);
        if (m_rvalid && unr) check_eq("m_rready_unrouted", m_rready, 1'b1);
        if (m_rvalid && !unr) begin
            check_eq("m_rready", m_rready, s_rready[rr]);
            check_eq("s_rid",    s_rid,    pend_q[0].id);
            check_eq("s_rdata",  s_rdata,  m_rdata);
            check_eq("s_rlast",  s_rlast,  m_rlast);
            check_eq("s_rresp",  s_rresp,  m_rresp);
        end
        check_eq("err_unrouted", err_unrouted, exp_err);

        if (rst) begin
            exp_busy = 1'b0;
            exp_last = N - 1;
            exp_err  = 1'b0;
            pend_q.delete();
        end else begin
            exp_err = m_rvalid && unr;
            r_hs    = m_rvalid && !unr && s_rready[rr];
            if (exp_busy) begin
                if (m_arready) begin
                    b.idx  = exp_g;
                    b.id   = req_id[exp_g];
                    b.len  = 32'(req_len[exp_g]);
                    b.beat = 0;
                    pend_q.push_back(b);
                    req_v[exp_g] = 1'b0;
                    exp_last = exp_g;
                    exp_busy = 1'b0;
                end
            end else begin
                found = 1'b0;
                for (int unsigned i = 1; i <= N; i++) begin
                    c = (exp_last + i) % N;
                    if (!found && req_v[c] && outs_of(c) < MAX_OUTS) begin
                        found    = 1'b1;
                        exp_g    = c;
                        exp_busy = 1'b1;
                    end
                end
            end
            if (r_hs) begin
                if (m_rlast) void'(pend_q.pop_front());
                else begin
                    b = pend_q[0];
                    b.beat++;
                    pend_q[0] = b;
                end
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_busy = 1'b0;
        exp_last = N - 1;
        exp_g    = 0;
        exp_err  = 1'b0;
        areset   = 1'b1;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = '0;
        m_rlast  = 1'b0;
        s_rready = '0;
        for (int unsigned k = 0; k < N; k++) new_req(k);
        drive_masters();

        for (int i = 0; i < 2; i++) step(1'b1, 100, 0, 0);
        for (int i = 0; i < 200; i++) step(1'b0, 100, 100, 90);
        for (int i = 0; i < 400; i++) step(1'b0, 100, 80, 5);
        for (int i = 0; i < 1500; i++) step(1'b0, 30, 70, 60);
        for (int i = 0; i < 2; i++) step(1'b1, 50, 0, 0);
        for (int i = 0; i < 800; i++)
            step(1'b0, 60, 60, (i % 200 < 100) ? 10 : 80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
